// File: rtl/log_pkg.sv
// Shared constants and types for the log stage of the mel pipeline.
package log_pkg;

  // ln(2) in unsigned Q0.16
  localparam int unsigned LN2_Q16 = 45426;

  // Pipeline depth of log2_ln_core (detect/normalise, multiply/saturate)
  localparam int unsigned CORE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/log2_ln_core.sv
// Two-stage pipelined x -> ln(x): leading-one detect plus Mitchell mantissa, then scale by ln2.
module log2_ln_core
  import log_pkg::*;
#(
  parameter int unsigned I_BW      = 30,
  parameter int unsigned O_BW      = 14,
  parameter int unsigned FRAC_BW   = 8,
  parameter int unsigned SHIFT     = 10,
  parameter int unsigned IDX_W     = 6,
  parameter int          LOG_FLOOR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [I_BW-1:0]  in_x,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [O_BW-1:0]  out_data
);

  localparam int unsigned M_W     = $clog2(I_BW);
  localparam int unsigned E_W     = $clog2(I_BW + SHIFT);
  localparam int unsigned L2_W    = E_W + FRAC_BW;
  localparam int unsigned P_W     = L2_W + 16 + O_BW;
  localparam int unsigned Q_W     = P_W - 16;
  localparam int unsigned MAX_POS = (2 ** (O_BW - 1)) - 1;

  logic [M_W-1:0]   msb_c;
  logic             pos_c;
  logic [I_BW-1:0]  norm_c;
  logic [FRAC_BW-1:0] frac_c;
  logic [L2_W-1:0]  l2_c;

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_pos;
  logic [L2_W-1:0]  s1_l2;

  logic [P_W-1:0]   prod_c;
  logic [Q_W-1:0]   q_c;
  logic [O_BW-1:0]  res_c;

  // Stage-1 combinational: find MSB, left-align the bits below it, form fixed-point log2
  always_comb begin
    msb_c = '0;
    for (int i = 0; i < int'(I_BW) - 1; i++) begin
      if (in_x[i]) msb_c = M_W'(i);
    end
    pos_c  = !in_x[I_BW-1] && (in_x != '0);
    norm_c = in_x << (M_W'(I_BW - 1) - msb_c);
    frac_c = FRAC_BW'(norm_c >> (I_BW - 1 - FRAC_BW));
    l2_c   = {E_W'(msb_c) + E_W'(SHIFT), frac_c};
  end

  // Stage-1 register
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_pos   <= 1'b0;
      s1_l2    <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_idx   <= in_idx;
      s1_pos   <= pos_c;
      s1_l2    <= l2_c;
    end
  end

  // Stage-2 combinational: scale log2 by ln2, truncate Q16, saturate, floor non-positive input
  always_comb begin
    prod_c = P_W'(s1_l2) * P_W'(LN2_Q16);
    q_c    = Q_W'(prod_c >> 16);
    if (!s1_pos)                 res_c = O_BW'(LOG_FLOOR);
    else if (q_c > Q_W'(MAX_POS)) res_c = O_BW'(MAX_POS);
    else                         res_c = O_BW'(q_c);
  end

  // Stage-2 register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_data  <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      out_idx   <= s1_idx;
      out_data  <= res_c;
    end
  end

endmodule

// File: rtl/log_frame_engine.sv
// Frame-buffered log stage: accepts one frame of N_CH energies, streams ln() per channel with backpressure.
module log_frame_engine
  import log_pkg::*;
#(
  parameter  int unsigned I_BW      = 30,
  parameter  int unsigned O_BW      = 14,
  parameter  int unsigned N_CH      = 64,
  parameter  int unsigned SHIFT     = 10,
  parameter  int unsigned FRAC_BW   = 8,
  parameter  int          LOG_FLOOR = 0,
  localparam int unsigned CH_W      = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [I_BW*N_CH-1:0]   data_i,
  input  logic [6:0]             in_group_num,
  input  logic                   di_en,
  output logic                   di_rdy,
  output logic [O_BW-1:0]        data_o,
  output logic [CH_W-1:0]        out_group_idx,
  output logic [6:0]             out_group_num,
  output logic                   do_en,
  input  logic                   do_rdy,
  output logic                   busy
);

  state_t             state;
  logic [I_BW*N_CH-1:0] frame_q;
  logic [6:0]         grp_q;
  logic [CH_W-1:0]    issue_cnt;

  logic               advance_c;
  logic               accept_c;
  logic               last_xfer_c;
  logic               issue_vld_c;

  logic               core_valid;
  logic [CH_W-1:0]    core_idx;
  logic [O_BW-1:0]    core_data;

  // Whole pipe moves unless a presented beat is being held off by downstream
  assign advance_c   = !do_en || do_rdy;
  assign accept_c    = di_en && di_rdy;
  assign last_xfer_c = do_en && do_rdy && (out_group_idx == CH_W'(N_CH - 1));
  assign issue_vld_c = (state == RUN);

  // Frame buffer capture on accept
  always_ff @(posedge clk) begin
    if (accept_c) frame_q <= data_i;
  end

  log2_ln_core #(
    .I_BW      (I_BW),
    .O_BW      (O_BW),
    .FRAC_BW   (FRAC_BW),
    .SHIFT     (SHIFT),
    .IDX_W     (CH_W),
    .LOG_FLOOR (LOG_FLOOR)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .en        (advance_c),
    .in_valid  (issue_vld_c),
    .in_idx    (issue_cnt),
    .in_x      (frame_q[issue_cnt*I_BW +: I_BW]),
    .out_valid (core_valid),
    .out_idx   (core_idx),
    .out_data  (core_data)
  );

  // Frame FSM, issue counter and registered output beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      di_rdy        <= 1'b1;
      busy          <= 1'b0;
      grp_q         <= '0;
      issue_cnt     <= '0;
      do_en         <= 1'b0;
      data_o        <= '0;
      out_group_idx <= '0;
      out_group_num <= '0;
    end else begin
      if (advance_c) begin
        do_en         <= core_valid;
        data_o        <= core_data;
        out_group_idx <= core_idx;
        out_group_num <= grp_q;
      end
      case (state)
        IDLE: begin
          if (accept_c) begin
            grp_q     <= in_group_num;
            issue_cnt <= '0;
            di_rdy    <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (advance_c) begin
            issue_cnt <= issue_cnt + CH_W'(1);
            if (issue_cnt == CH_W'(N_CH - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_xfer_c) begin
            di_rdy <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log_frame_engine.sv
// Self-checking bench for log_frame_engine: O_BW=14 instance plus an O_BW=12 instance for saturation.
module tb_log_frame_engine;

  localparam int I_BW = 30;
  localparam int N_CH = 64;
  localparam int FW   = I_BW * N_CH;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] data_i;
  logic [6:0]    in_group_num;
  logic          di_en;
  logic          do_rdy;

  logic          di_rdy_a, do_en_a, busy_a;
  logic [13:0]   data_a;
  logic [5:0]    idx_a;
  logic [6:0]    num_a;

  logic          di_rdy_b, do_en_b, busy_b;
  logic [11:0]   data_b;
  logic [5:0]    idx_b;
  logic [6:0]    num_b;

  int checks   = 0;
  int failures = 0;

  longint exp14[N_CH];
  longint exp12[N_CH];

  always #5 clk = ~clk;

  log_frame_engine dut_a (
    .clk(clk), .rst(rst), .data_i(data_i), .in_group_num(in_group_num), .di_en(di_en),
    .di_rdy(di_rdy_a), .data_o(data_a), .out_group_idx(idx_a), .out_group_num(num_a),
    .do_en(do_en_a), .do_rdy(do_rdy), .busy(busy_a)
  );

  log_frame_engine #(.O_BW(12)) dut_b (
    .clk(clk), .rst(rst), .data_i(data_i), .in_group_num(in_group_num), .di_en(di_en),
    .di_rdy(di_rdy_b), .data_o(data_b), .out_group_idx(idx_b), .out_group_num(num_b),
    .do_en(do_en_b), .do_rdy(do_rdy), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: ln(x) from the log2 definition using plain integer arithmetic
  function automatic longint ln_model(input longint x, input int obw);
    longint m, frac, l2, r, mx;
    if (x <= 0) return 0;
    m = 0;
    while ((64'sd1 <<< (m + 1)) <= x) m++;
    frac = ((x - (64'sd1 <<< m)) * 256) / (64'sd1 <<< m);
    l2   = ((m + 10) * 256) + frac;
    r    = (l2 * 45426) / 65536;
    mx   = (64'sd1 <<< (obw - 1)) - 1;
    return (r > mx) ? mx : r;
  endfunction

  function automatic void fill_model(input logic [FW-1:0] f);
    logic signed [I_BW-1:0] v;
    for (int k = 0; k < N_CH; k++) begin
      v = f[k*I_BW +: I_BW];
      exp14[k] = ln_model(longint'(v), 14);
      exp12[k] = ln_model(longint'(v), 12);
    end
  endfunction

  function automatic logic [FW-1:0] gen_frame();
    logic [FW-1:0] f;
    logic [I_BW-1:0] v;
    for (int k = 0; k < N_CH; k++) begin
      v = I_BW'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) v = -v;
      f[k*I_BW +: I_BW] = v;
    end
    return f;
  endfunction

  // Present one frame and consume all its beats; optionally keep di_en high with the next frame,
  // or stop as soon as beat stop_at is presented.
  task automatic run_frame(input logic [FW-1:0] f, input logic [6:0] num, input int rdy_pct,
                           input bit chk_lat, input bit hold_next, input logic [FW-1:0] f_next,
                           input logic [6:0] num_next, input bit expect_now, input int stop_at);
    int  w = 0;
    int  c = 0;
    int  ei = 0;
    bit  p_stall = 1'b0;
    while (!di_rdy_a && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (w >= 300) begin
      failures++;
      $error("FAIL accept_timeout observed=%0d expected=<300", w);
      return;
    end
    if (expect_now) check("accept_wait", 64'(w), 64'd0);
    data_i = f; in_group_num = num; di_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (hold_next) begin data_i = f_next; in_group_num = num_next; end
    else di_en = 1'b0;
    check("run_di_rdy", 64'(di_rdy_a), 64'd0);
    check("run_busy", 64'(busy_a), 64'd1);
    while (ei < N_CH) begin
      @(negedge clk);
      c++;
      if (c > 3000) begin
        failures++;
        $error("FAIL beat_timeout observed=%0d expected=%0d", ei, N_CH);
        return;
      end
      if (p_stall) check("stall_hold_en", 64'(do_en_a), 64'd1);
      if (do_en_a) begin
        check("data14", 64'(data_a), 64'(exp14[ei]));
        check("data12", 64'(data_b), 64'(exp12[ei]));
        check("idx", 64'(idx_a), 64'(ei));
        check("num", 64'(num_a), 64'(num));
        if (chk_lat) check("latency", 64'(c), 64'(3 + ei));
        if (ei == stop_at) return;
      end
      do_rdy  = ($urandom_range(0, 99) < rdy_pct);
      p_stall = do_en_a && !do_rdy;
      if (do_en_a && do_rdy) ei++;
    end
    @(negedge clk);
    check("end_di_rdy", 64'(di_rdy_a), 64'd1);
    check("end_busy", 64'(busy_a), 64'd0);
    check("end_do_en", 64'(do_en_a), 64'd0);
  endtask

  initial begin
    logic [FW-1:0] f, f2;
    logic [FW-1:0] zero_f;
    zero_f = '0;
    rst = 1'b1; di_en = 1'b0; do_rdy = 1'b0; data_i = '0; in_group_num = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_di_rdy", 64'(di_rdy_a), 64'd1);
    check("rst_do_en", 64'(do_en_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_data", 64'(data_a), 64'd0);
    check("rst_idx", 64'(idx_a), 64'd0);
    check("rst_num", 64'(num_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All ones: ln = 10*ln2 in Q8, fixed latency with no backpressure
    for (int k = 0; k < N_CH; k++) f[k*I_BW +: I_BW] = I_BW'(1);
    for (int k = 0; k < N_CH; k++) begin exp14[k] = 1774; exp12[k] = 1774; end
    run_frame(f, 7'd5, 100, 1'b1, 1'b0, zero_f, 7'd0, 1'b0, -1);

    // Mixed values including zero and negative inputs
    f = gen_frame();
    f[0*I_BW +: I_BW] = I_BW'(1024);
    f[1*I_BW +: I_BW] = I_BW'(3);
    f[2*I_BW +: I_BW] = I_BW'(0);
    f[3*I_BW +: I_BW] = I_BW'(-5);
    fill_model(f);
    exp14[0] = 3548; exp14[1] = 2040; exp14[2] = 0; exp14[3] = 0;
    exp12[0] = 2047; exp12[1] = 2040; exp12[2] = 0; exp12[3] = 0;
    run_frame(f, 7'd17, 100, 1'b1, 1'b0, zero_f, 7'd0, 1'b0, -1);

    // Largest positive input: 6919 at 14 bits, saturates at 12 bits
    for (int k = 0; k < N_CH; k++) f[k*I_BW +: I_BW] = I_BW'((1 << 29) - 1);
    for (int k = 0; k < N_CH; k++) begin exp14[k] = 6919; exp12[k] = 2047; end
    run_frame(f, 7'd88, 100, 1'b0, 1'b0, zero_f, 7'd0, 1'b0, -1);

    // Random data with random backpressure
    for (int n = 0; n < 3; n++) begin
      f = gen_frame();
      fill_model(f);
      run_frame(f, 7'(20 + n), 50, 1'b0, 1'b0, zero_f, 7'd0, 1'b0, -1);
    end

    // di_en held through the frame with new data; taken only after the last beat
    f  = gen_frame();
    f2 = gen_frame();
    fill_model(f);
    run_frame(f, 7'd40, 70, 1'b0, 1'b1, f2, 7'd41, 1'b0, -1);
    fill_model(f2);
    run_frame(f2, 7'd41, 70, 1'b0, 1'b0, zero_f, 7'd0, 1'b1, -1);

    // Reset while beat 20 is on the output, then a clean frame
    f = gen_frame();
    fill_model(f);
    run_frame(f, 7'd60, 100, 1'b1, 1'b0, zero_f, 7'd0, 1'b0, 20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_do_en", 64'(do_en_a), 64'd0);
    check("abort_data", 64'(data_a), 64'd0);
    check("abort_idx", 64'(idx_a), 64'd0);
    check("abort_di_rdy", 64'(di_rdy_a), 64'd1);
    check("abort_busy", 64'(busy_a), 64'd0);
    do_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_quiet", 64'(do_en_a), 64'd0);
    end
    f = gen_frame();
    fill_model(f);
    run_frame(f, 7'd61, 100, 1'b1, 1'b0, zero_f, 7'd0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
